life_scan_gen: RTL and testbench
================================

# life_scan_gen

Raster-scan generator that reads the Life board from row-organised memory and serialises it, one cell per transfer, into the cell pipe's `new_data` input. It is the producing end of the serial cell stream: the delay-line/neighbourhood logic consumes one bit per clock, and this block supplies those bits in row-major order with a valid/ready handshake. Row reads are prefetched so the stream runs without bubbles when `ready` is held high.

## Interface
- `X`, 8, board width in cells (X ≥ 2)
- `Y`, 8, board height in rows (Y ≥ 2)
- `LOG2X`, 3, column counter width, ceil(log2 X)
- `LOG2Y`, 3, row address width, ceil(log2 Y)
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins one board scan when idle
- `ready`  in  1  downstream accepts the current cell
- `new_data`  out  1  current cell value
- `new_valid`  out  1  `new_data` is valid
- `mem_rd`  out  1  row read strobe
- `mem_addr`  out  LOG2Y  row address
- `mem_rdata`  in  X  row data, valid exactly one cycle after `mem_rd`; bit c = column c
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse after the final cell transfer

## Operation
- States: IDLE, FETCH, PRIME, STREAM.
- IDLE: `start`=1 → FETCH. `start` in any other state is ignored.
- FETCH: `mem_rd`=1, `mem_addr`=first row → PRIME.
- PRIME: capture `mem_rdata` into the current-row register, column = 0 → STREAM.
- STREAM: `new_valid`=1, `new_data`=cur_row[col]. A transfer occurs when `new_valid && ready`. On a transfer, col increments; `ready`=0 freezes col, `new_data` and `new_valid`.
- Prefetch: on the transfer of col X-2, if rows remain, `mem_rd`=1 with the next row address. The returned row is held in next_row.
- On the transfer of col X-1:
  - If the read was issued in the previous cycle, the current row loads from `mem_rdata` directly (bypass). Otherwise it loads from next_row.
  - col wraps to 0 and the row index increments.
- After the last row's col X-1 transfer: go to IDLE, `new_valid`=0, `done`=1 for one cycle.
- `busy`=1 in FETCH, PRIME and STREAM.
- Row index counter is LOG2Y+1 bits. Address = (index + offset) mod Y; no out-of-range address is ever driven.

## Timing
- Reset values: `new_valid`=0, `new_data`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- `start` sampled in cycle 0. `mem_rd` in cycle 1. First `new_valid` in cycle 3.
- With `ready` held high, the stream is gap-free: X·R consecutive valid cycles, where R is the number of emitted rows.
- `done` is asserted the cycle after the final transfer. `busy` deasserts in the same cycle.
- Simultaneous `start` and the final transfer: `start` is ignored.
- `rst_n` low mid-scan: all outputs go to reset values immediately. A pending read is discarded.

## Configuration
- `LIFE_SCAN_WRAP_EN` defined: toroidal halo rows. Emits row Y-1, rows 0..Y-1, then row 0, so R = Y+2.
- Undefined: emits rows 0..Y-1 only, so R = Y.
- Column order and handshake are identical in both builds.

## Structure
- Shared package `life_pkg` holds:
  - state encoding constants (IDLE/FETCH/PRIME/STREAM);
  - the derived rows-per-scan constant, selected by `LIFE_SCAN_WRAP_EN`.
- One sub-module, `life_row_buf`, holds cur_row and next_row, the bypass mux, and the `new_data` bit select. FSM and counters stay in the top.

## Test plan
All cases use X=8, Y=8.
- Reset then idle: no `start` for 20 cycles → `new_valid`, `mem_rd`, `busy`, `done` stay 0.
- Full scan, `ready`=1, rows hold pattern 8'hA5 ^ row:
  - first valid in cycle 3;
  - 64 contiguous cells, LSB first;
  - `done` at cycle 67;
  - `mem_rd` for row r+1 on the col-6 transfer of row r.
- Random `ready` (≈50%): cell sequence identical to the full-scan case; `new_data` stable whenever `ready`=0; `mem_rd` never asserted twice for one row.
- `ready` low exactly during the col-7 cycle of each row: next_row path is used and no data is lost.
- `LIFE_SCAN_WRAP_EN` build: 80 cells; `mem_addr` sequence 7,0,1,…,7,0.
- `rst_n` pulsed low mid-row 3:
  - outputs zero asynchronously;
  - a new `start` rescans from row 0 (row 7 when `LIFE_SCAN_WRAP_EN` is defined).

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Life raster-scan generator.
// LIFE_SCAN_WRAP_EN adds toroidal halo rows (row Y-1 before the board, row 0 after).
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_PRIME  = 2'd2,
    S_STREAM = 2'd3
  } scan_state_e;

`ifdef LIFE_SCAN_WRAP_EN
  localparam int HALO_ROWS = 2;
`else
  localparam int HALO_ROWS = 0;
`endif

  function automatic int rows_per_scan(input int y);
    return y + HALO_ROWS;
  endfunction

endpackage

// File: rtl/life_scan_gen_if.sv
// Cell stream (valid/ready) and row-memory read port of the Life scan generator.
interface life_scan_gen_if #(
  parameter int X     = 8,
  parameter int LOG2Y = 3
);
  logic             new_data;
  logic             new_valid;
  logic             ready;
  logic             mem_rd;
  logic [LOG2Y-1:0] mem_addr;
  logic [X-1:0]     mem_rdata;

  modport master (
    output new_data, new_valid, mem_rd, mem_addr,
    input  ready, mem_rdata
  );

  modport slave (
    input  new_data, new_valid, mem_rd, mem_addr,
    output ready, mem_rdata
  );
endinterface

// File: rtl/life_row_buf.sv
// Current/next row registers for the scan generator, with read-data bypass
// and the per-column bit select that drives the serial cell output.
module life_row_buf #(
  parameter int X     = 8,
  parameter int LOG2X = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prime_i,
  input  logic             rd_pend_i,
  input  logic             advance_i,
  input  logic             valid_i,
  input  logic [X-1:0]     rdata_i,
  input  logic [LOG2X-1:0] col_i,
  output logic             data_o
);

  logic [X-1:0] cur_row_q, cur_row_d;
  logic [X-1:0] next_row_q, next_row_d;

  always_comb begin
    cur_row_d  = cur_row_q;
    next_row_d = next_row_q;
    if (rd_pend_i) next_row_d = rdata_i;
    if (prime_i) begin
      cur_row_d = rdata_i;
    end else if (advance_i) begin
      // Read data arriving this very cycle has not reached next_row yet.
      cur_row_d = rd_pend_i ? rdata_i : next_row_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row_q  <= '0;
      next_row_q <= '0;
    end else begin
      cur_row_q  <= cur_row_d;
      next_row_q <= next_row_d;
    end
  end

  assign data_o = valid_i & cur_row_q[col_i];

endmodule

// File: rtl/life_scan_gen.sv
// Raster-scan generator: reads board rows and serialises them row-major, LSB first,
// onto a valid/ready cell stream with one-row prefetch. Option: LIFE_SCAN_WRAP_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | read strobe for the first emitted row
//   PRIME  | first row data captured into the current-row register
//   STREAM | cells presented; prefetch of the next row at column X-2
module life_scan_gen
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  life_scan_gen_if.master bus
);

  localparam int R          = rows_per_scan(Y);
  localparam int ROW_OFFSET = (HALO_ROWS != 0) ? Y - 1 : 0;
  localparam logic [LOG2X-1:0] COL_LAST = LOG2X'(X - 1);
  localparam logic [LOG2X-1:0] COL_PRE  = LOG2X'(X - 2);
  localparam logic [LOG2Y:0]   ROW_LAST = (LOG2Y + 1)'(R - 1);

  scan_state_e      state_q, state_d;
  logic [LOG2X-1:0] col_q, col_d;
  logic [LOG2Y:0]   row_q, row_d;
  logic             done_q, done_d;
  logic             rd_pend_q;
  logic             rd;
  logic [LOG2Y:0]   rd_idx;
  logic             prime;
  logic             advance;

  function automatic logic [LOG2Y-1:0] row_addr(input logic [LOG2Y:0] idx);
    int unsigned sum;
    sum = 32'(idx) + ROW_OFFSET;
    return LOG2Y'(sum % Y);
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    rd      = 1'b0;
    rd_idx  = '0;
    prime   = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FETCH: begin
        rd      = 1'b1;
        state_d = S_PRIME;
      end
      S_PRIME: begin
        prime   = 1'b1;
        col_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bus.ready) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            advance = 1'b1;
            if (row_q == ROW_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
            if (col_q == COL_PRE && row_q != ROW_LAST) begin
              rd     = 1'b1;
              rd_idx = row_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      done_q    <= done_d;
      rd_pend_q <= rd && (state_q == S_STREAM);
    end
  end

  life_row_buf #(.X(X), .LOG2X(LOG2X)) u_row_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .prime_i   (prime),
    .rd_pend_i (rd_pend_q),
    .advance_i (advance),
    .valid_i   (bus.new_valid),
    .rdata_i   (bus.mem_rdata),
    .col_i     (col_q),
    .data_o    (bus.new_data)
  );

  assign bus.new_valid = (state_q == S_STREAM);
  assign bus.mem_rd    = rd;
  assign bus.mem_addr  = rd ? row_addr(rd_idx) : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_life_scan_gen.sv
// Self-checking bench for life_scan_gen against a row-list reference model.
module tb_life_scan_gen;
  localparam int X = 8, Y = 8, LOG2X = 3, LOG2Y = 3;
`ifdef LIFE_SCAN_WRAP_EN
  localparam int R = Y + 2;
`else
  localparam int R = Y;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  int   n_vec = 0;
  int   n_err = 0;
  logic [X-1:0] mem [Y];

  life_scan_gen_if #(.X(X), .LOG2Y(LOG2Y)) bus ();

  life_scan_gen #(.X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Row memory: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : X'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready, start held high; 2: ready low on each col X-1 once
  task automatic run_scan(input int mode, input int stop_cells);
    int   rows[$];
    bit   exp_bits[$];
    int   cells, reads, cyc, first_valid;
    bit   prev_stall, prev_data, held, got_done, rdy;
`ifdef LIFE_SCAN_WRAP_EN
    rows.push_back(Y - 1);
`endif
    for (int r = 0; r < Y; r++) rows.push_back(r);
`ifdef LIFE_SCAN_WRAP_EN
    rows.push_back(0);
`endif
    foreach (rows[i]) begin
      logic [X-1:0] rv;
      rv = mem[rows[i]];
      for (int c = 0; c < X; c++) exp_bits.push_back(rv[c]);
    end
    cells = 0; reads = 0; first_valid = -1;
    prev_stall = 0; prev_data = 0; held = 0; got_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = (mode == 1);
    cyc = 1;
    while (cyc < 1000 && !got_done) begin
      case (mode)
        1: rdy = $urandom_range(0, 1);
        2: begin
          if (bus.new_valid && (cells % X == X - 1) && !held) begin
            rdy = 0; held = 1;
          end else rdy = 1;
        end
        default: rdy = 1;
      endcase
      bus.ready = rdy;
      @(negedge clk);
      if (stop_cells >= 0 && cells >= stop_cells) return;
      if (bus.mem_rd) begin
        chk("rd_count", reads < R, 1);
        if (reads < R) chk("mem_addr", bus.mem_addr, rows[reads]);
        if (reads > 0) chk("prefetch_col", (cells % X == X - 2) && bus.new_valid && bus.ready, 1);
        else chk("fetch_cycle", cyc, 1);
        reads++;
      end
      if (prev_stall) begin
        chk("stall_valid", bus.new_valid, 1);
        chk("stall_data", bus.new_data, prev_data);
      end
      if (bus.new_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("first_valid_cyc", cyc, 3);
        end
        chk("cell_in_range", cells < X * R, 1);
        if (cells < X * R) chk("cell", bus.new_data, exp_bits[cells]);
        if (mode == 0) chk("gapless", cyc, cells + 3);
      end
      if (done) begin
        got_done = 1;
        start = 1'b0;
        chk("done_cells", cells, X * R);
        chk("done_busy", busy, 0);
        chk("done_valid", bus.new_valid, 0);
        chk("done_reads", reads, R);
        if (mode == 0) chk("done_cyc", cyc, X * R + 3);
      end else begin
        chk("busy", busy, 1);
      end
      prev_stall = bus.new_valid && !bus.ready;
      prev_data  = bus.new_data;
      if (bus.new_valid && bus.ready) begin
        cells++;
        held = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("scan_timeout", got_done, 1);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", bus.new_valid, 0);
  endtask

  initial begin
    bus.ready = 1'b0;
    for (int r = 0; r < Y; r++) mem[r] = X'(8'hA5 ^ r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.new_valid, 0);
    chk("rst_data", bus.new_data, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst_n = 1'b1;

    // idle with no start
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", bus.new_valid, 0);
      chk("idle_rd", bus.mem_rd, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end

    run_scan(0, -1);
    run_scan(1, -1);
    run_scan(2, -1);

    for (int r = 0; r < Y; r++) mem[r] = X'($urandom);
    run_scan(1, -1);
    run_scan(2, -1);

    // async reset in the middle of row 3
    for (int r = 0; r < Y; r++) mem[r] = X'(8'hA5 ^ r);
    run_scan(0, 3 * X + 3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.new_valid, 0);
    chk("arst_data", bus.new_data, 0);
    chk("arst_rd", bus.mem_rd, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
